// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS control blocks.
//
// Contents:
//   *_op     six-bit opcode values
//   *_f      six-bit R-type function-field values
//   alu_*    five-bit ALU operation codes. Wider ALU-op buses zero-extend these codes.
//   pc_*     PC source select values
//   state_t  multi-cycle controller state encoding
//   uses_imm helper that flags opcodes whose ALU B operand is the immediate
//
// Configuration macro: MC_CTRL_MULDIV_EN. It enables the mult/div decode in the users of
// this package. The constants themselves are always present.
package mips_pkg;

    // Opcodes
    localparam logic [5:0] rtype_op = 6'b000000;
    localparam logic [5:0] j_op     = 6'b000010;
    localparam logic [5:0] beq_op   = 6'b000100;
    localparam logic [5:0] addi_op  = 6'b001000;
    localparam logic [5:0] ori_op   = 6'b001101;
    localparam logic [5:0] lw_op    = 6'b100011;
    localparam logic [5:0] sw_op    = 6'b101011;

    // R-type function fields
    localparam logic [5:0] add_f  = 6'b100000;
    localparam logic [5:0] addu_f = 6'b100001;
    localparam logic [5:0] subu_f = 6'b100011;
    localparam logic [5:0] and_f  = 6'b100100;
    localparam logic [5:0] or_f   = 6'b100101;
    localparam logic [5:0] slt_f  = 6'b101010;
    localparam logic [5:0] mult_f = 6'b011000;
    localparam logic [5:0] div_f  = 6'b011010;

    // ALU operation codes
    localparam logic [4:0] alu_add  = 5'b00000;
    localparam logic [4:0] alu_addu = 5'b00001;
    localparam logic [4:0] alu_subu = 5'b00010;
    localparam logic [4:0] alu_and  = 5'b00011;
    localparam logic [4:0] alu_or   = 5'b00100;
    localparam logic [4:0] alu_slt  = 5'b00101;
    localparam logic [4:0] alu_mult = 5'b00110;
    localparam logic [4:0] alu_div  = 5'b00111;

    // PC source selects
    localparam logic [1:0] pc_seq    = 2'd0;
    localparam logic [1:0] pc_branch = 2'd1;
    localparam logic [1:0] pc_jump   = 2'd2;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        MDWAIT
    } state_t;

    // Every I-type instruction except beq feeds the extended immediate into ALU input B.
    // beq compares two registers instead.
    function automatic logic uses_imm(input logic [5:0] op);
        return (op == addi_op) || (op == ori_op) || (op == lw_op) || (op == sw_op);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: purely combinational instruction decoder. It maps op/funct to an ALU
// operation code and a legality flag. It has no state, so other cores can reuse it.
//
// Parameters:
//   ALUOP_W  width of the aluop output. It must be at least 5, and the codes are
//            zero-extended to this width.
// Ports:
//   op     in   6        opcode
//   funct  in   6        R-type function field
//   aluop  out  ALUOP_W  ALU operation code. It is meaningless when legal is 0.
//   legal  out  1        1 when the op/funct pair is a supported instruction
//
// Configuration macro: MC_CTRL_MULDIV_EN. It adds the mult/div function codes. Without
// it, those function codes decode as illegal.
module mc_alu_dec
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] aluop,
    output logic               legal
);

    logic [4:0] code;

    // Decode the opcode first. The function field only matters for R-type instructions.
    // A jump does not use the ALU, so its code is a harmless add.
    always_comb begin
        code  = alu_add;
        legal = 1'b1;
        case (op)
            rtype_op: begin
                case (funct)
                    add_f:   code = alu_add;
                    addu_f:  code = alu_addu;
                    subu_f:  code = alu_subu;
                    and_f:   code = alu_and;
                    or_f:    code = alu_or;
                    slt_f:   code = alu_slt;
`ifdef MC_CTRL_MULDIV_EN
                    mult_f:  code = alu_mult;
                    div_f:   code = alu_div;
`endif
                    default: legal = 1'b0;
                endcase
            end
            lw_op, sw_op, addi_op: code = alu_add;
            ori_op:                code = alu_or;
            beq_op:                code = alu_subu;
            j_op:                  code = alu_add;
            default:               legal = 1'b0;
        endcase
        aluop = ALUOP_W'(code);
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller. It steps each instruction through the states
// FETCH / DECODE / EXEC / MEM / WB and handshakes with memory through mem_req and
// mem_ready. It drives the datapath strobes and mux selects, and it raises a sticky
// illegal flag when it sees an unknown instruction or a memory timeout.
//
// Every output is a register. Each output reflects the state the controller has just
// entered, so a strobe caused by a decision in one state becomes visible in the
// following cycle. The IR datapath is expected to present the newly fetched instruction
// on op/funct during DECODE.
//
// Parameters:
//   ALUOP_W  ALU-op width. It must be at least 5.
//   MEM_TO   maximum number of cycles to wait on mem_ready before the timeout error.
//            It must be at least 1.
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   op, funct   instruction fields, sampled in DECODE
//   zero        ALU zero flag, used by beq in EXEC
//   mem_ready   completion strobe for the outstanding memory request
//   mem_req     memory request, held until mem_ready
//   mem_we      store qualifier, valid while mem_req is high
//   ir_we       IR load pulse
//   pc_we       PC write pulse
//   pc_src      PC source select
//   reg_we      register-file write pulse
//   reg_dst     register-file write select (rd or rt)
//   mem_to_reg  write-back data select (load data or ALU result)
//   alu_src_b   ALU B-operand select
//   aluop       ALU operation code, valid from EXEC through WB
//   illegal     sticky error flag
//   md_done     multiply/divide completion. This port exists only with MC_CTRL_MULDIV_EN.
//
// Configuration macro: MC_CTRL_MULDIV_EN. It adds mult/div and the MDWAIT state.
module mc_ctrl #(
    parameter int ALUOP_W = 5,
    parameter int MEM_TO  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_b,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal
`ifdef MC_CTRL_MULDIV_EN
    ,
    input  logic               md_done
`endif
);

    import mips_pkg::*;

    localparam int CNT_W = $clog2(MEM_TO + 1);

    state_t             state;
    logic [5:0]         op_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_legal;
    logic               timeout;

    mc_alu_dec #(
        .ALUOP_W(ALUOP_W)
    ) u_dec (
        .op    (op),
        .funct (funct),
        .aluop (dec_aluop),
        .legal (dec_legal)
    );

    // wait_cnt holds the number of cycles already spent waiting. The cycle now in
    // progress is the final allowed cycle when wait_cnt reaches MEM_TO-1.
    assign timeout = (wait_cnt == CNT_W'(MEM_TO - 1));

    // This single block updates the state register, the wait counter and all registered
    // outputs.
    //
    // The pulse strobes return to 0 on every clock edge unless a transition sets them.
    //
    // FETCH is entered from reset with mem_req still low. The first FETCH cycle only
    // raises the request. Any mem_ready seen while mem_req is low is stale and ignored.
    //
    // When mem_ready arrives in the same cycle as the timeout, the completion is checked
    // first and wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            op_q       <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            ir_we      <= 1'b0;
            pc_we      <= 1'b0;
            pc_src     <= pc_seq;
            reg_we     <= 1'b0;
            reg_dst    <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src_b  <= 1'b0;
            aluop      <= '0;
            illegal    <= 1'b0;
        end else begin
            ir_we  <= 1'b0;
            pc_we  <= 1'b0;
            reg_we <= 1'b0;
            case (state)
                FETCH: begin
                    mem_we <= 1'b0;
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        state    <= DECODE;
                        mem_req  <= 1'b0;
                        ir_we    <= 1'b1;
                        pc_we    <= 1'b1;
                        pc_src   <= pc_seq;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= HALT;
                        mem_req  <= 1'b0;
                        illegal  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    op_q <= op;
                    if (!dec_legal) begin
                        state   <= HALT;
                        illegal <= 1'b1;
                    end else if (op == j_op) begin
                        state   <= FETCH;
                        pc_we   <= 1'b1;
                        pc_src  <= pc_jump;
                        mem_req <= 1'b1;
                    end else begin
                        state     <= EXEC;
                        aluop     <= dec_aluop;
                        alu_src_b <= uses_imm(op);
                    end
                end
                EXEC: begin
                    if (op_q == beq_op) begin
                        state   <= FETCH;
                        pc_we   <= zero;
                        pc_src  <= pc_branch;
                        mem_req <= 1'b1;
                    end else if (op_q == lw_op || op_q == sw_op) begin
                        state   <= MEM;
                        mem_req <= 1'b1;
                        mem_we  <= (op_q == sw_op);
                    end
`ifdef MC_CTRL_MULDIV_EN
                    else if (op_q == rtype_op &&
                             (aluop == ALUOP_W'(alu_mult) || aluop == ALUOP_W'(alu_div))) begin
                        state <= MDWAIT;
                    end
`endif
                    else begin
                        state      <= WB;
                        reg_we     <= 1'b1;
                        reg_dst    <= (op_q == rtype_op);
                        mem_to_reg <= 1'b0;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        mem_we   <= 1'b0;
                        if (op_q == sw_op) begin
                            state <= FETCH;
                        end else begin
                            state      <= WB;
                            mem_req    <= 1'b0;
                            reg_we     <= 1'b1;
                            reg_dst    <= 1'b0;
                            mem_to_reg <= 1'b1;
                        end
                    end else if (timeout) begin
                        state    <= HALT;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        illegal  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WB: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
`ifdef MC_CTRL_MULDIV_EN
                MDWAIT: begin
                    if (md_done) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
`endif
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state   <= HALT;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl with the default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// strb packs the strobes as {mem_req, mem_we, ir_we, pc_we, reg_we}.
// Configuration macro: MC_CTRL_MULDIV_EN, which adds the mult sequence.
module tb_mc_ctrl;

    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we;
    logic [1:0] pc_src;
    logic       reg_dst, mem_to_reg, alu_src_b, illegal;
    logic [4:0] aluop;
    logic [4:0] strb;
`ifdef MC_CTRL_MULDIV_EN
    logic       md_done = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    assign strb = {mem_req, mem_we, ir_we, pc_we, reg_we};

    mc_ctrl #(
        .ALUOP_W(5),
        .MEM_TO (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .illegal    (illegal)
`ifdef MC_CTRL_MULDIV_EN
        ,
        .md_done    (md_done)
`endif
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Global watchdog so that the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic z,
                                 input logic [5:0] o, input logic [5:0] f);
        mem_ready = rdy;
        zero      = z;
        op        = o;
        funct     = f;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each directed step lists its expected values, which were worked out by hand from
    // the state sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, rtype_op, add_f);
        #12;
        checkOutput("rst_strb", 8'(strb), 8'b00000);
        checkOutput("rst_pcsrc", 8'(pc_src), 8'd0);
        checkOutput("rst_aluop", 8'(aluop), 8'd0);
        checkOutput("rst_illegal", 8'(illegal), 8'd0);
        checkOutput("rst_sel", 8'({reg_dst, mem_to_reg, alu_src_b}), 8'b000);
        @(negedge clk);
        rst = 1'b0;

        // add, with fetch ready delayed by 2 cycles
        tick(); checkOutput("add_fetch0", 8'(strb), 8'b10000);
        tick(); checkOutput("add_fetch1", 8'(strb), 8'b10000);
        tick(); checkOutput("add_fetch2", 8'(strb), 8'b10000);
        applyStimulus(1'b1, 1'b0, rtype_op, add_f);
        tick(); checkOutput("add_decode", 8'(strb), 8'b00110);
        checkOutput("add_pcsrc", 8'(pc_src), 8'd0);
        applyStimulus(1'b0, 1'b0, rtype_op, add_f);
        tick(); checkOutput("add_exec", 8'(strb), 8'b00000);
        checkOutput("add_aluop", 8'(aluop), 8'(alu_add));
        checkOutput("add_srcb", 8'(alu_src_b), 8'd0);
        tick(); checkOutput("add_wb", 8'(strb), 8'b00001);
        checkOutput("add_wbsel", 8'({reg_dst, mem_to_reg}), 8'b10);
        tick(); checkOutput("add_next", 8'(strb), 8'b10000);

        // lw: the fetch completes at once, then the memory stage waits 3 cycles
        applyStimulus(1'b1, 1'b0, lw_op, 6'd0);
        tick(); checkOutput("lw_decode", 8'(strb), 8'b00110);
        applyStimulus(1'b0, 1'b0, lw_op, 6'd0);
        tick(); checkOutput("lw_exec", 8'(strb), 8'b00000);
        checkOutput("lw_srcb", 8'(alu_src_b), 8'd1);
        checkOutput("lw_aluop", 8'(aluop), 8'(alu_add));
        tick(); checkOutput("lw_mem0", 8'(strb), 8'b10000);
        tick(); tick(); tick();
        checkOutput("lw_mem3", 8'(strb), 8'b10000);
        applyStimulus(1'b1, 1'b0, lw_op, 6'd0);
        tick(); checkOutput("lw_wb", 8'(strb), 8'b00001);
        checkOutput("lw_wbsel", 8'({reg_dst, mem_to_reg}), 8'b01);
        applyStimulus(1'b0, 1'b0, lw_op, 6'd0);
        tick(); checkOutput("lw_next", 8'(strb), 8'b10000);

        // beq taken (zero=1)
        applyStimulus(1'b1, 1'b0, beq_op, 6'd0);
        tick(); checkOutput("beq1_decode", 8'(strb), 8'b00110);
        applyStimulus(1'b0, 1'b1, beq_op, 6'd0);
        tick(); checkOutput("beq1_aluop", 8'(aluop), 8'(alu_subu));
        checkOutput("beq1_srcb", 8'(alu_src_b), 8'd0);
        tick(); checkOutput("beq1_strb", 8'(strb), 8'b10010);
        checkOutput("beq1_pcsrc", 8'(pc_src), 8'd1);

        // beq not taken (zero=0)
        applyStimulus(1'b1, 1'b0, beq_op, 6'd0);
        tick(); checkOutput("beq0_decode", 8'(strb), 8'b00110);
        applyStimulus(1'b0, 1'b0, beq_op, 6'd0);
        tick();
        tick(); checkOutput("beq0_strb", 8'(strb), 8'b10000);

        // j
        applyStimulus(1'b1, 1'b0, j_op, 6'd0);
        tick(); checkOutput("j_decode", 8'(strb), 8'b00110);
        applyStimulus(1'b0, 1'b0, j_op, 6'd0);
        tick(); checkOutput("j_strb", 8'(strb), 8'b10010);
        checkOutput("j_pcsrc", 8'(pc_src), 8'd2);

        // ori
        applyStimulus(1'b1, 1'b0, ori_op, 6'd0);
        tick();
        applyStimulus(1'b0, 1'b0, ori_op, 6'd0);
        tick(); checkOutput("ori_aluop", 8'(aluop), 8'(alu_or));
        checkOutput("ori_srcb", 8'(alu_src_b), 8'd1);
        tick(); checkOutput("ori_wb", 8'(strb), 8'b00001);
        checkOutput("ori_wbsel", 8'({reg_dst, mem_to_reg}), 8'b00);
        tick();

`ifdef MC_CTRL_MULDIV_EN
        // mult: waits in MDWAIT for md_done and never writes the register file
        applyStimulus(1'b1, 1'b0, rtype_op, mult_f);
        tick();
        applyStimulus(1'b0, 1'b0, rtype_op, mult_f);
        tick(); checkOutput("mult_aluop", 8'(aluop), 8'(alu_mult));
        tick(); checkOutput("mult_wait0", 8'(strb), 8'b00000);
        tick(); checkOutput("mult_wait1", 8'(strb), 8'b00000);
        md_done = 1'b1;
        tick(); checkOutput("mult_done", 8'(strb), 8'b10000);
        md_done = 1'b0;
`endif

        // slt
        applyStimulus(1'b1, 1'b0, rtype_op, slt_f);
        tick();
        applyStimulus(1'b0, 1'b0, rtype_op, slt_f);
        tick(); checkOutput("slt_aluop", 8'(aluop), 8'(alu_slt));
        tick(); checkOutput("slt_wbsel", 8'({reg_dst, mem_to_reg}), 8'b10);
        tick();

        // Illegal funct 000111: the controller halts and its outputs freeze.
        applyStimulus(1'b1, 1'b0, rtype_op, 6'b000111);
        tick(); checkOutput("ill_decode", 8'(strb), 8'b00110);
        tick(); checkOutput("ill_halt", 8'(strb), 8'b00000);
        checkOutput("ill_flag", 8'(illegal), 8'd1);
        tick(); tick(); tick();
        checkOutput("ill_frozen", 8'(strb), 8'b00000);
        checkOutput("ill_sticky", 8'(illegal), 8'd1);
        checkOutput("ill_aluop", 8'(aluop), 8'(alu_slt));
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ill_rst", 8'(illegal), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        // mem_ready is still high, but it is stale while mem_req is low.
        applyStimulus(1'b1, 1'b0, sw_op, 6'd0);
        tick(); checkOutput("stale_ready", 8'(strb), 8'b10000);
        tick(); checkOutput("sw_decode", 8'(strb), 8'b00110);

        // sw: ready arrives on the 8th MEM cycle, the timeout cycle, and the access
        // completes.
        applyStimulus(1'b0, 1'b0, sw_op, 6'd0);
        tick();
        tick(); checkOutput("sw_mem", 8'(strb), 8'b11000);
        repeat (7) tick();
        checkOutput("sw_mem7", 8'(strb), 8'b11000);
        checkOutput("sw_mem7_ill", 8'(illegal), 8'd0);
        applyStimulus(1'b1, 1'b0, sw_op, 6'd0);
        tick(); checkOutput("sw_late_done", 8'(strb), 8'b10000);
        checkOutput("sw_late_ill", 8'(illegal), 8'd0);

        // sw with mem_ready withheld for 8 cycles: the controller times out.
        tick(); checkOutput("swto_decode", 8'(strb), 8'b00110);
        applyStimulus(1'b0, 1'b0, sw_op, 6'd0);
        tick();
        tick(); checkOutput("swto_mem", 8'(strb), 8'b11000);
        repeat (7) tick();
        checkOutput("swto_7", 8'(illegal), 8'd0);
        tick(); checkOutput("swto_8_ill", 8'(illegal), 8'd1);
        checkOutput("swto_8_strb", 8'(strb), 8'b00000);

        // Reset asserted mid-MEM drops mem_req without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(); checkOutput("rm_fetch", 8'(strb), 8'b10000);
        applyStimulus(1'b1, 1'b0, lw_op, 6'd0);
        tick();
        applyStimulus(1'b0, 1'b0, lw_op, 6'd0);
        tick();
        tick(); checkOutput("rm_mem", 8'(strb), 8'b10000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rm_async", 8'(mem_req), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(); checkOutput("rm_restart", 8'(strb), 8'b10000);
        checkOutput("rm_illegal", 8'(illegal), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
